// File: rtl/pcs_rx_block_sync_pkg.sv
// Shared constants, state encoding and sync-header helper for the 66b RX block-lock logic.
package pcs_rx_block_sync_pkg;

    localparam int LEN_CODED_BLOCK = 66;
    localparam int NB_INDEX        = 7;

    localparam logic [1:0] SH_DATA = 2'b01;
    localparam logic [1:0] SH_CTRL = 2'b10;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_TEST = 2'd1,
        ST_SLIP = 2'd2
    } sync_state_e;

    function automatic logic sh_is_valid(input logic [1:0] sh);
        return (sh == SH_DATA) || (sh == SH_CTRL);
    endfunction

endpackage

// File: rtl/pcs_rx_block_sync_if.sv
// Gearbox-side input and aligned-block output bundle of the RX block sync.
// BLOCK_SYNC_STATS_EN adds the slip and lock-loss statistics counters.
interface pcs_rx_block_sync_if;
    import pcs_rx_block_sync_pkg::*;

    logic                       i_enable;
    logic [LEN_CODED_BLOCK-1:0] i_data;
    logic [LEN_CODED_BLOCK-1:0] o_data;
    logic                       o_valid;
    logic                       o_block_lock;
    logic [NB_INDEX-1:0]        o_index;
`ifdef BLOCK_SYNC_STATS_EN
    logic [15:0]                o_slip_count;
    logic [15:0]                o_lock_loss_count;
`endif

    modport master (
        output i_enable, i_data,
        input  o_data, o_valid, o_block_lock, o_index
`ifdef BLOCK_SYNC_STATS_EN
        , input o_slip_count, o_lock_loss_count
`endif
    );

    modport slave (
        input  i_enable, i_data,
        output o_data, o_valid, o_block_lock, o_index
`ifdef BLOCK_SYNC_STATS_EN
        , output o_slip_count, o_lock_loss_count
`endif
    );

endinterface

// File: rtl/pcs_rx_block_sync_sh_offset_mux.sv
// Selects the 66b candidate block at the current offset from the 132b window
// and flags whether its sync header is a legal 01/10 pattern.
module pcs_rx_block_sync_sh_offset_mux
    import pcs_rx_block_sync_pkg::*;
(
    input  logic [2*LEN_CODED_BLOCK-1:0] win_i,
    input  logic [NB_INDEX-1:0]          index_i,
    output logic [LEN_CODED_BLOCK-1:0]   cand_o,
    output logic                         sh_valid_o
);

    logic [2*LEN_CODED_BLOCK-1:0] shifted_s;

    // Shift the window left by the offset so the candidate always sits in the upper half.
    always_comb begin
        shifted_s  = win_i << index_i;
        cand_o     = shifted_s[2*LEN_CODED_BLOCK-1 -: LEN_CODED_BLOCK];
        sh_valid_o = sh_is_valid(cand_o[LEN_CODED_BLOCK-1 -: 2]);
    end

endmodule

// File: rtl/pcs_rx_block_sync.sv
// 66b block lock: hunts the sync-header offset, declares/drops lock, emits aligned blocks.
// Optional BLOCK_SYNC_STATS_EN adds saturating slip and lock-loss counters.
module pcs_rx_block_sync
    import pcs_rx_block_sync_pkg::*;
#(
    parameter int LOCK_GOOD   = 64,
    parameter int WINDOW      = 1024,
    parameter int MAX_INVALID = 65
) (
    input  logic               i_clock,
    input  logic               i_reset,
    pcs_rx_block_sync_if.slave bus
);

    localparam logic [10:0]         LOCK_GOOD_C   = 11'(LOCK_GOOD);
    localparam logic [10:0]         WINDOW_C      = 11'(WINDOW);
    localparam logic [6:0]          MAX_INVALID_C = 7'(MAX_INVALID);
    localparam logic [NB_INDEX-1:0] LAST_INDEX_C  = NB_INDEX'(LEN_CODED_BLOCK - 1);

    sync_state_e                state_q, state_d;
    logic [NB_INDEX-1:0]        index_q, index_d;
    logic [10:0]                sh_cnt_q, sh_cnt_d;
    logic [6:0]                 sh_inv_q, sh_inv_d;
    logic                       lock_q, lock_d;
    logic [LEN_CODED_BLOCK-1:0] prev_word_q, data_q;
    logic                       valid_q;

    logic [LEN_CODED_BLOCK-1:0] cand_s;
    logic                       sh_valid_s;
    logic [10:0]                cnt_inc_s;
    logic [6:0]                 inv_inc_s;
    logic                       test_s, slip_req_s, lose_s, gain_s, win_end_s;

    pcs_rx_block_sync_sh_offset_mux u_mux (
        .win_i      ({prev_word_q, bus.i_data}),
        .index_i    (index_q),
        .cand_o     (cand_s),
        .sh_valid_o (sh_valid_s)
    );

    assign cnt_inc_s  = sh_cnt_q + 11'd1;
    assign inv_inc_s  = sh_inv_q + {6'd0, ~sh_valid_s};
    assign test_s     = (state_q == ST_TEST) && bus.i_enable;
    // Loss of lock takes priority over a window boundary on the same header.
    assign lose_s     = test_s && lock_q && (inv_inc_s == MAX_INVALID_C);
    assign slip_req_s = test_s && !lock_q && !sh_valid_s;
    assign gain_s     = test_s && !lock_q && sh_valid_s &&
                        (cnt_inc_s == LOCK_GOOD_C) && (inv_inc_s == 7'd0);
    assign win_end_s  = test_s && lock_q && !lose_s && (cnt_inc_s == WINDOW_C);

    // State and datapath registers.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q     <= ST_INIT;
            index_q     <= {NB_INDEX{1'b0}};
            sh_cnt_q    <= 11'd0;
            sh_inv_q    <= 7'd0;
            lock_q      <= 1'b0;
            prev_word_q <= {LEN_CODED_BLOCK{1'b0}};
            data_q      <= {LEN_CODED_BLOCK{1'b0}};
            valid_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            index_q  <= index_d;
            sh_cnt_q <= sh_cnt_d;
            sh_inv_q <= sh_inv_d;
            lock_q   <= lock_d;
            valid_q  <= bus.i_enable & lock_q;
            if (bus.i_enable) begin
                prev_word_q <= bus.i_data;
                data_q      <= cand_s;
            end
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT: state_d = ST_TEST;
            ST_TEST: begin
                if (slip_req_s || lose_s) begin
                    state_d = ST_SLIP;
                end else begin
                    state_d = ST_TEST;
                end
            end
            ST_SLIP: state_d = ST_TEST;
            default: state_d = ST_INIT;
        endcase
    end

    // Counter, offset and lock updates per state.
    always_comb begin
        index_d  = index_q;
        sh_cnt_d = sh_cnt_q;
        sh_inv_d = sh_inv_q;
        lock_d   = lock_q;
        case (state_q)
            ST_TEST: begin
                if (!test_s) begin
                    sh_cnt_d = sh_cnt_q;
                end else if (slip_req_s || lose_s || gain_s || win_end_s) begin
                    sh_cnt_d = 11'd0;
                    sh_inv_d = 7'd0;
                end else begin
                    sh_cnt_d = cnt_inc_s;
                    sh_inv_d = inv_inc_s;
                end
                if (lose_s) begin
                    lock_d = 1'b0;
                end else if (gain_s) begin
                    lock_d = 1'b1;
                end else begin
                    lock_d = lock_q;
                end
            end
            ST_SLIP: begin
                if (index_q == LAST_INDEX_C) begin
                    index_d = {NB_INDEX{1'b0}};
                end else begin
                    index_d = index_q + {{(NB_INDEX-1){1'b0}}, 1'b1};
                end
                sh_cnt_d = 11'd0;
                sh_inv_d = 7'd0;
            end
            default: begin
                sh_cnt_d = 11'd0;
                sh_inv_d = 7'd0;
            end
        endcase
    end

    assign bus.o_data       = data_q;
    assign bus.o_valid      = valid_q;
    assign bus.o_block_lock = lock_q;
    assign bus.o_index      = index_q;

`ifdef BLOCK_SYNC_STATS_EN
    logic [15:0] slip_cnt_q, loss_cnt_q;

    // Saturating counts of slip entries and lock losses.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            slip_cnt_q <= 16'd0;
            loss_cnt_q <= 16'd0;
        end else begin
            if ((state_q == ST_TEST) && (state_d == ST_SLIP) && (slip_cnt_q != 16'hFFFF)) begin
                slip_cnt_q <= slip_cnt_q + 16'd1;
            end
            if (lock_q && !lock_d && (loss_cnt_q != 16'hFFFF)) begin
                loss_cnt_q <= loss_cnt_q + 16'd1;
            end
        end
    end

    assign bus.o_slip_count      = slip_cnt_q;
    assign bus.o_lock_loss_count = loss_cnt_q;
`endif

endmodule
